// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path.
// The menu/text stage and the scan driver both use these letter codes.
// Segment bit order: bit0 = a ... bit6 = g.
package seg_pkg;

  localparam int SEG_W = 7;
  localparam int N_DIG = 4;
  localparam int IDX_W = 2;

  typedef logic [SEG_W-1:0] seg_code_t;

  localparam seg_code_t SEG_BLANK = 7'd0;

  // Letter glyphs. Some letters are lower-case shapes because a
  // seven-segment digit cannot draw the capital form.
  localparam seg_code_t SEG_A = 7'd119;  // 0x77
  localparam seg_code_t SEG_B = 7'd124;  // 0x7C  b
  localparam seg_code_t SEG_C = 7'd57;   // 0x39
  localparam seg_code_t SEG_D = 7'd94;   // 0x5E  d
  localparam seg_code_t SEG_E = 7'd121;  // 0x79
  localparam seg_code_t SEG_F = 7'd113;  // 0x71
  localparam seg_code_t SEG_G = 7'd61;   // 0x3D
  localparam seg_code_t SEG_H = 7'd118;  // 0x76
  localparam seg_code_t SEG_I = 7'd48;   // 0x30
  localparam seg_code_t SEG_J = 7'd30;   // 0x1E
  localparam seg_code_t SEG_K = 7'd117;  // 0x75
  localparam seg_code_t SEG_L = 7'd56;   // 0x38
  localparam seg_code_t SEG_M = 7'd55;   // 0x37
  localparam seg_code_t SEG_N = 7'd84;   // 0x54  n
  localparam seg_code_t SEG_O = 7'd63;   // 0x3F
  localparam seg_code_t SEG_P = 7'd115;  // 0x73
  localparam seg_code_t SEG_Q = 7'd103;  // 0x67  q
  localparam seg_code_t SEG_R = 7'd80;   // 0x50  r
  localparam seg_code_t SEG_S = 7'd109;  // 0x6D
  localparam seg_code_t SEG_T = 7'd120;  // 0x78  t
  localparam seg_code_t SEG_U = 7'd62;   // 0x3E
  localparam seg_code_t SEG_V = 7'd28;   // 0x1C  v
  localparam seg_code_t SEG_W_ = 7'd42;  // 0x2A  (SEG_W is the width)
  localparam seg_code_t SEG_X = 7'd73;   // 0x49
  localparam seg_code_t SEG_Y = 7'd110;  // 0x6E
  localparam seg_code_t SEG_Z = 7'd91;   // 0x5B

  // Phase of the current digit slot.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } slot_phase_e;

  // One-hot anode pattern for a digit index.
  function automatic logic [N_DIG-1:0] onehot_an(input logic [IDX_W-1:0] idx);
    return N_DIG'(1) << idx;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Digit-slot timer: counts DIV cycles per slot and steps the digit index
// through 0..N_DIG-1. Reports the last cycle of a slot, the last cycle of
// a frame, and whether the slot is still in its leading blank gap.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int DIV       = 27000,
  parameter int BLANK_CYC = 270
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx,
  output logic             slot_end,
  output logic             wrap,
  output logic             in_blank
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign slot_end = (cnt_q == CNT_W'(DIV - 1));
  assign wrap     = slot_end && (idx_q == IDX_W'(N_DIG - 1));
  assign idx      = idx_q;

  // A zero-length gap needs no comparator at all.
  if (BLANK_CYC == 0) begin : g_no_gap
    assign in_blank = 1'b0;
  end else begin : g_gap
    assign in_blank = (cnt_q < CNT_W'(BLANK_CYC));
  end

  // Next slot count and digit index.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a value unassigned and infers a latch.
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 1'b1;  // wraps 3 -> 0 naturally at 2 bits
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment scan driver.
// Latches the 28-bit display word once per frame (digit k = bits
// [7k+6:7k]) and time-multiplexes it onto one shared segment bus with
// one-hot anode enables, inserting a blank gap at the start of each slot.
// Build option SEG_ACTIVE_LOW_EN: invert seg and an at the output
// register for common-anode boards (blank/reset then drive all-ones).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV       = 27000,
  parameter int BLANK_CYC = 270
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] display_in,
  input  logic        freeze,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [SEG_W-1:0] SEG_OFF = ~SEG_BLANK;
  localparam logic [N_DIG-1:0] AN_OFF  = '1;
`else
  localparam logic [SEG_W-1:0] SEG_OFF = SEG_BLANK;
  localparam logic [N_DIG-1:0] AN_OFF  = '0;
`endif

  logic [IDX_W-1:0] idx;
  logic             slot_end;
  logic             wrap;
  logic             in_blank;

  seg_slot_timer #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx),
    .slot_end (slot_end),
    .wrap     (wrap),
    .in_blank (in_blank)
  );

  logic                        first_q, first_d;
  logic [N_DIG-1:0][SEG_W-1:0] shadow_q, shadow_d;
  logic [SEG_W-1:0]            seg_q, seg_d;
  logic [N_DIG-1:0]            an_q, an_d;
  logic [IDX_W-1:0]            digit_idx_q, digit_idx_d;
  logic                        frame_tick_q, frame_tick_d;

  logic                        frame_load;
  slot_phase_e                 phase;
  logic [SEG_W-1:0]            seg_raw;
  logic [N_DIG-1:0]            an_raw;

  // A frame starts on the first cycle out of reset and on the last cycle
  // of digit 3's slot.
  assign frame_load = first_q || (slot_end && wrap);
  assign phase      = in_blank ? PH_BLANK : PH_DRIVE;

  // Frame latch: capture the word at a frame boundary unless frozen.
  always_comb begin
    first_d      = 1'b0;
    shadow_d     = shadow_q;
    frame_tick_d = frame_load;
    if (frame_load && !freeze) begin
      shadow_d = display_in;
    end
  end

  // Digit mux and output polarity, registered one cycle after the counter.
  always_comb begin
    seg_raw = SEG_BLANK;
    an_raw  = '0;
    unique case (phase)
      PH_DRIVE: begin
        seg_raw = shadow_q[idx];
        an_raw  = onehot_an(idx);
      end
      default: ;
    endcase
`ifdef SEG_ACTIVE_LOW_EN
    seg_d = ~seg_raw;
    an_d  = ~an_raw;
`else
    seg_d = seg_raw;
    an_d  = an_raw;
`endif
    digit_idx_d = idx;
  end

  // Frame latch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow word is a plain register (not a RAM), so it is
      // reset like any other flop and shows blank until the first load.
      first_q      <= 1'b1;
      shadow_q     <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      digit_idx_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      first_q      <= first_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      digit_idx_q  <= digit_idx_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIV=8). Two instances share the
// stimulus: one with a 2-cycle blank gap, one with no gap. Expected values
// come from a time-based model: output after edge e reflects slot position
// p=e-1 (cnt=p%8, digit=(p/8)%4) and the word latched at edge 1 or at
// every edge that is a multiple of 32.
module tb_seg_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int NDIG  = 4;
  localparam int FRAME = DIV * NDIG;

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;
`else
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [3:0] AN_OFF  = 4'h0;
`endif

  localparam logic [27:0] W_HOLA = {7'd118, 7'd63, 7'd56, 7'd119};
  localparam logic [27:0] W_OOOO = {7'd63, 7'd63, 7'd63, 7'd63};
  localparam logic [27:0] W_CAFE = {7'd57, 7'd119, 7'd113, 7'd121};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] display_in;
  logic        freeze;
  logic [6:0]  seg, seg0;
  logic [3:0]  an, an0;
  logic [1:0]  digit_idx, digit_idx0;
  logic        frame_tick, frame_tick0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .display_in(display_in), .freeze(freeze),
    .seg(seg), .an(an), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  seg_scan_driver #(.DIV(DIV), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .display_in(display_in), .freeze(freeze),
    .seg(seg0), .an(an0), .digit_idx(digit_idx0), .frame_tick(frame_tick0)
  );

  typedef struct packed {
    logic [27:0]      load_word;
    logic             load_frz;
    logic [27:0]      mid_word;
    logic [3:0][6:0]  exp;       // expected code shown on digit k
  } frame_vec_t;

  frame_vec_t tbl [4];

  int checks = 0;
  int errors = 0;
  int e;                 // rising edges since reset release
  logic [27:0] sh_m;     // model of the latched word
  bit tbl_on = 0;
  int tick_cnt = 0;
  int an0_off_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)", name, act, exp, e, $time);
    end
  endtask

  function automatic logic [6:0] pol_seg(input logic [6:0] s);
`ifdef SEG_ACTIVE_LOW_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  function automatic logic [3:0] pol_an(input logic [3:0] a);
`ifdef SEG_ACTIVE_LOW_EN
    return ~a;
`else
    return a;
`endif
  endfunction

  // Expected bus state for slot position p, given the latched word.
  function automatic void model_out(input int p, input logic [27:0] sh, input int blank,
                                    output logic [6:0] s, output logic [3:0] a);
    int c, k;
    logic [3:0] one;
    c = p % DIV;
    k = (p / DIV) % NDIG;
    one = 4'b0001;
    if (c < blank) begin
      s = 7'd0;
      a = 4'd0;
    end else begin
      s = sh[7*k +: 7];
      a = one << k;
    end
    s = pol_seg(s);
    a = pol_an(a);
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_seg"},   32'(seg),         32'(SEG_OFF));
    check({tag, "_an"},    32'(an),          32'(AN_OFF));
    check({tag, "_idx"},   32'(digit_idx),   32'd0);
    check({tag, "_tick"},  32'(frame_tick),  32'd0);
    check({tag, "_seg0"},  32'(seg0),        32'(SEG_OFF));
    check({tag, "_an0"},   32'(an0),         32'(AN_OFF));
  endtask

  // Advance one clock and compare both instances against the model.
  task automatic step();
    int p, c, k, fidx;
    logic [6:0] es, es0;
    logic [3:0] ea, ea0;
    logic       et;
    @(posedge clk);
    e++;
    p = e - 1;
    c = p % DIV;
    k = (p / DIV) % NDIG;
    model_out(p, sh_m, BLANK, es, ea);
    model_out(p, sh_m, 0, es0, ea0);
    et = (e == 1) || (e % FRAME == 0);
    if (et && !freeze) sh_m = display_in;
    #1;
    check("seg",      32'(seg),         32'(es));
    check("an",       32'(an),          32'(ea));
    check("idx",      32'(digit_idx),   32'(k));
    check("tick",     32'(frame_tick),  32'(et));
    check("seg_nogap", 32'(seg0),       32'(es0));
    check("an_nogap",  32'(an0),        32'(ea0));
    check("idx_nogap", 32'(digit_idx0), 32'(k));
    check("tick_nogap", 32'(frame_tick0), 32'(et));
    if (e >= 2 && an0 == AN_OFF) an0_off_seen++;
    if (tbl_on) begin
      if (frame_tick && e >= FRAME + 1) tick_cnt++;
      fidx = p / FRAME;
      if (fidx < 4 && c >= BLANK && e >= 2)
        check("tbl_seg", 32'(seg), 32'(pol_seg(tbl[fidx].exp[k])));
    end
  endtask

  initial begin
    int load_e;

    tbl[0] = '{load_word: W_HOLA, load_frz: 1'b0, mid_word: W_OOOO, exp: W_HOLA};
    tbl[1] = '{load_word: W_OOOO, load_frz: 1'b0, mid_word: W_HOLA, exp: W_OOOO};
    tbl[2] = '{load_word: W_CAFE, load_frz: 1'b1, mid_word: W_CAFE, exp: W_OOOO};
    tbl[3] = '{load_word: W_CAFE, load_frz: 1'b0, mid_word: W_HOLA, exp: W_CAFE};

    rst_n      = 1'b0;
    display_in = W_HOLA;
    freeze     = 1'b0;
    e          = 0;
    sh_m       = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame-by-frame table: load word, freeze at the load edge, then a
    // mid-frame word change during slot 1 that must stay invisible.
    tbl_on = 1;
    for (int f = 0; f < 4; f++) begin
      load_e = (f == 0) ? 1 : FRAME * f;
      display_in = tbl[f].load_word;
      freeze     = tbl[f].load_frz;
      while (e < load_e) step();
      freeze = 1'b0;
      while (e < load_e + 10) step();
      display_in = tbl[f].mid_word;
      while (e < FRAME * (f + 1) - 1) step();
    end
    step();  // edge 128: next frame load
    tbl_on = 0;
    check("ticks_per_frame", 32'(tick_cnt), 32'd3);

    // Async reset at slot 2, cycle 5 of the frame.
    while (e % FRAME != 2 * DIV + 5) step();
    check("pre_reset_an", 32'(an), 32'(pol_an(4'b0100)));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    display_in = W_CAFE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e     = 0;
    sh_m  = '0;

    // Randomized words and freeze, checked against the model.
    for (int i = 0; i < 10 * FRAME; i++) begin
      step();
      display_in = 28'($urandom);
      freeze     = ($urandom_range(0, 3) == 0);
    end

    check("nogap_an_never_off", 32'(an0_off_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
